invd2_nd2d2_ring_model: RTL and testbench
=========================================

// Module: invd2_nd2d2_ring_model
// PURPOSE
//  Cycle-based, synthesizable model of the VCO ring oscillator built from one ND2D2 enable-NAND and
//  INVD2 inverter stages. One clk cycle = one gate delay. Used in the odometer datapath for
//  digital simulation and FPGA emulation where the free-running analog ring cannot be used.
//  Adds a saturating rising-edge counter on the buffered output for aging/frequency checks.
// PARAMETERS
//  STAGES    101  ring length: stage 1 = NAND(en, fb), stages 2..STAGES = inverters. Must be odd, >=3.
//  LOAD_DLY  1    extra feedback delay in cycles, models the wire/load delay. Must be >=1.
//  CNT_W     16   width of the rising-edge counter.
// PORTS
//  clk        in   1      single clock; every ring node updates on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  en_vco     in   1      ring enable; 1 = oscillate, 0 = force ring to static state
//  out        out  1      buffered ring output = ~fb (models the INVD2 load inverter)
//  rise_cnt   out  CNT_W  number of 0->1 transitions of out, saturating
//  running    out  1      1 while at least one out toggle occurred in the last 2*(STAGES+LOAD_DLY) cycles
// BEHAVIOUR
//  Interface: one clock (clk); rst asynchronous, active-high. Everything else is synchronous to clk.
//  Nodes w[1..STAGES] are registers. The feedback fb = w[STAGES] passes through a LOAD_DLY-deep
//   shift register d[1..LOAD_DLY]; fb = d[LOAD_DLY].
//  Per clk: w[1] <= ~(en_vco & fb); w[i+1] <= ~w[i]; d[1] <= w[STAGES]; d[k+1] <= d[k].
//  out = ~fb, combinational from the last delay register (no extra latency).
//  Reset (async): w[i] = 1 for odd i, 0 for even i. Because STAGES is odd, w[STAGES] = 1 and all
//   d[k] = 1, so fb = 1 and out = 0. rise_cnt = 0, running = 0, idle timer = 0.
//  Loop latency L = STAGES + LOAD_DLY. The loop has an odd number of inversions, so with en_vco=1
//   out toggles every L cycles. Full period = 2*L cycles (default 204).
//  Start-up: en_vco is first sampled high at edge 0 -> out rises right after edge L, falls after 2L,
//   rises after 3L, and so on.
//  Disable: en_vco sampled low -> w[1] is forced to 1 on the next edge. The ring settles to the reset
//   pattern within L cycles and out ends at 0. If out was 1, it falls exactly once and never glitches.
//   Re-enable resumes with the start-up timing, measured from the re-enable edge.
//  rise_cnt: +1 on each cycle where out goes 0->1. It holds at 2^CNT_W-1 and does not wrap. Its value
//   is kept through disable and is cleared only by rst.
//  running: an idle timer is cleared on any out toggle and increments otherwise, saturating.
//   running = (timer < 2*L).
//  Reset mid-oscillation: all state returns to reset values immediately, regardless of clk.
//  Elaboration check: $error if STAGES is even, STAGES<3, or LOAD_DLY<1.
// STRUCTURE
//  Shared package invd2_nd2d2_pkg: default constants RING_STAGES=101 and RING_LOAD_DLY=1, plus
//   function ring_period(stages, dly) = 2*(stages+dly), used by the RTL and the bench.
//  One sub-module, ro_stage_reg: a single resettable register gate stage with parameters
//   IS_NAND (0/1) and RST_VAL. The top instantiates it STAGES times in a generate loop.
//  The feedback delay line, edge detector, counter and idle timer live in the top module.
// TESTING
//  Run with STAGES=5, LOAD_DLY=1 (L=6, period 12) and also with the defaults (L=102, period 204).
//  1. Reset with en_vco=0 -> out=0, rise_cnt=0, running=0, w=10101; hold 50 cycles -> nothing changes.
//  2. Raise en_vco at edge 0 -> out=1 after edge 6, 0 after 12, 1 after 18. After 120 cycles,
//     rise_cnt=10. running goes 1 at edge 6.
//  3. Defaults: enable for 2040 cycles -> rise_cnt=10, out high time exactly 102 cycles.
//  4. Drop en_vco while out=1 -> out falls once within 6 cycles and stays 0. rise_cnt frozen.
//     running goes 0 within 12 cycles after the last toggle. Re-enable -> first rise 6 cycles later.
//  5. CNT_W=4, run 20 periods -> rise_cnt saturates at 15 and does not wrap.
//  6. Assert rst asynchronously mid-period while out=1 -> out=0 and rise_cnt=0 before the next clk edge.
//     Release rst with en_vco=1 -> first rise 6 cycles after release.

Source files
------------

// File: rtl/invd2_nd2d2_pkg.sv
// Shared constants and helpers for the INVD2/ND2D2 ring oscillator model.
package invd2_nd2d2_pkg;

    localparam int RING_STAGES   = 101;
    localparam int RING_LOAD_DLY = 1;
    localparam int RING_CNT_W    = 16;

    // Full oscillation period in clk cycles: two trips around the loop.
    function automatic int ring_period(input int stages, input int dly);
        return 2 * (stages + dly);
    endfunction

endpackage

// File: rtl/invd2_nd2d2_ring_model_ro_stage_reg.sv
// One registered gate stage of the ring: NAND(en, a) or INV(a), one clk = one gate delay.
module ro_stage_reg
    import invd2_nd2d2_pkg::*;
#(
    parameter bit IS_NAND = 1'b0,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    output logic q
);

    logic q_q;
    logic q_d;

    // Gate function; inverter stages ignore the enable leg.
    always_comb begin
        q_d = ~(a & (IS_NAND ? en : 1'b1));
    end

    // Stage register with asynchronous reset to its static ring value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/invd2_nd2d2_ring_model.sv
// Cycle-based ring oscillator model: NAND + inverter chain, feedback delay line,
// saturating rising-edge counter on the buffered output and an activity monitor.
module invd2_nd2d2_ring_model
    import invd2_nd2d2_pkg::*;
#(
    parameter int STAGES   = RING_STAGES,
    parameter int LOAD_DLY = RING_LOAD_DLY,
    parameter int CNT_W    = RING_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_vco,
    output logic             out,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             running
);

    localparam int PERIOD = ring_period(STAGES, LOAD_DLY);
    localparam int TMR_W  = $clog2(PERIOD + 1);

    if ((STAGES % 2) == 0 || STAGES < 3 || LOAD_DLY < 1) begin : g_bad_params
        $error("invd2_nd2d2_ring_model: STAGES must be odd and >=3, LOAD_DLY must be >=1");
    end

    // node[0] is the NAND stage (w1), node[STAGES-1] is the last inverter (w[STAGES]).
    logic [STAGES-1:0]   node;
    logic                fb;
    logic [LOAD_DLY-1:0] dly_q, dly_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                running_q, running_d;
    logic                toggle;
    logic                rise;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // Reset pattern alternates 1,0,1,... starting at w1, so the ring is static when disabled.
        ro_stage_reg #(
            .IS_NAND ((i == 0)),
            .RST_VAL (((i % 2) == 0))
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en_vco),
            .a   ((i == 0) ? fb : node[(i == 0) ? 0 : i - 1]),
            .q   (node[i])
        );
    end

    assign fb  = dly_q[LOAD_DLY-1];
    assign out = ~fb;

    // Delay line, edge detection, counter and idle timer next-state.
    always_comb begin
        dly_d[0] = node[STAGES-1];
        for (int k = 1; k < LOAD_DLY; k++) begin
            dly_d[k] = dly_q[k-1];
        end
        // The toggle is seen one step early so the counter and monitor update
        // on the same edge that changes out.
        toggle = (dly_d[LOAD_DLY-1] != dly_q[LOAD_DLY-1]);
        rise   = toggle & fb;

        cnt_d = cnt_q;
        if (rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

        tmr_d = tmr_q;
        if (toggle)                          tmr_d = '0;
        else if (tmr_q < TMR_W'(PERIOD))     tmr_d = tmr_q + TMR_W'(1);

        // running stays low after reset until the first real toggle.
        running_d = toggle | (running_q & (tmr_d < TMR_W'(PERIOD)));
    end

    // State registers; delay line resets to 1 so fb=1 and out=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q     <= '1;
            cnt_q     <= '0;
            tmr_q     <= '0;
            running_q <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            running_q <= running_d;
        end
    end

    assign rise_cnt = cnt_q;
    assign running  = running_q;

endmodule

// File: tb/tb_invd2_nd2d2_ring_model.sv
// Directed bench for the ring oscillator model at STAGES=5 and default sizes.
module tb_invd2_nd2d2_ring_model;
    import invd2_nd2d2_pkg::*;

    logic clk;
    logic rst_a, en_a, out_a, run_a;
    logic rst_b, en_b, out_b, run_b;
    logic rst_c, en_c, out_c, run_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    invd2_nd2d2_ring_model #(.STAGES(5), .LOAD_DLY(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst_a), .en_vco(en_a), .out(out_a), .rise_cnt(cnt_a), .running(run_a));

    invd2_nd2d2_ring_model #(.STAGES(RING_STAGES), .LOAD_DLY(RING_LOAD_DLY), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst_b), .en_vco(en_b), .out(out_b), .rise_cnt(cnt_b), .running(run_b));

    invd2_nd2d2_ring_model #(.STAGES(5), .LOAD_DLY(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst_c), .en_vco(en_c), .out(out_c), .rise_cnt(cnt_c), .running(run_c));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b0;  en_b = 1'b0;  en_c = 1'b0;
    end

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic changed;
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL reset_out: got %0b expected 0", out_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", run_a); end
        checks++; if (u_a.node !== 5'b10101) begin errors++; $display("FAIL reset_nodes: got %b expected 10101", u_a.node); end
        changed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_a !== 1'b0 || cnt_a !== 16'd0 || run_a !== 1'b0 || u_a.node !== 5'b10101) changed = 1'b1;
        end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL idle_hold: state changed while disabled, got %0b expected 0", changed); end
        checks++; if (out_b !== 1'b0) begin errors++; $display("FAIL reset_out_b: got %0b expected 0", out_b); end
    endtask

    task automatic test_startup();
        int bad_edge;
        logic exp_out;
        bad_edge = -1;
        en_a = 1'b1;
        for (int e = 1; e <= 120; e++) begin
            tick();
            exp_out = ((e / 6) % 2) == 1;
            if (out_a !== exp_out && bad_edge < 0) bad_edge = e;
            if (e == 5) begin
                checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL start_run_e5: got %0b expected 0", run_a); end
            end
            if (e == 6) begin
                checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL start_rise_e6: got %0b expected 1", out_a); end
                checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL start_run_e6: got %0b expected 1", run_a); end
            end
            if (e == 12) begin
                checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL start_fall_e12: got %0b expected 0", out_a); end
            end
        end
        checks++; if (bad_edge !== -1) begin errors++; $display("FAIL start_trace: first wrong edge %0d expected none (-1)", bad_edge); end
        checks++; if (cnt_a !== 16'd10) begin errors++; $display("FAIL start_cnt120: got %0d expected 10", cnt_a); end
    endtask

    task automatic test_disable();
        int waited, falls, rises, fall_tick;
        logic prev;
        waited = 0;
        while (out_a !== 1'b1 && waited < 20) begin tick(); waited++; end
        checks++; if (waited !== 6) begin errors++; $display("FAIL dis_wait_rise: got %0d expected 6", waited); end
        en_a = 1'b0;
        falls = 0; rises = 0; fall_tick = -1; prev = out_a;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (prev === 1'b1 && out_a === 1'b0) begin falls++; fall_tick = t; end
            if (prev === 1'b0 && out_a === 1'b1) rises++;
            prev = out_a;
        end
        checks++; if (fall_tick !== 6) begin errors++; $display("FAIL dis_fall_tick: got %0d expected 6", fall_tick); end
        checks++; if (falls !== 1) begin errors++; $display("FAIL dis_falls: got %0d expected 1", falls); end
        checks++; if (rises !== 0) begin errors++; $display("FAIL dis_rises: got %0d expected 0", rises); end
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL dis_run_11: got %0b expected 1", run_a); end
        tick();
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL dis_run_12: got %0b expected 0", run_a); end
        checks++; if (cnt_a !== 16'd11) begin errors++; $display("FAIL dis_cnt_frozen: got %0d expected 11", cnt_a); end
        checks++; if (u_a.node !== 5'b10101) begin errors++; $display("FAIL dis_settled: got %b expected 10101", u_a.node); end
        repeat (10) tick();
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL dis_out_low: got %0b expected 0", out_a); end
        en_a = 1'b1;
        repeat (5) tick();
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL reen_e5: got %0b expected 0", out_a); end
        tick();
        checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL reen_e6: got %0b expected 1", out_a); end
        checks++; if (cnt_a !== 16'd12) begin errors++; $display("FAIL reen_cnt: got %0d expected 12", cnt_a); end
    endtask

    task automatic test_defaults();
        int first_rise, run_len, runs, bad_len;
        logic prev;
        first_rise = -1; run_len = 0; runs = 0; bad_len = -1;
        prev = out_b;
        en_b = 1'b1;
        for (int e = 1; e <= 2040; e++) begin
            tick();
            if (prev === 1'b0 && out_b === 1'b1 && first_rise < 0) first_rise = e;
            if (out_b === 1'b1) run_len++;
            if (prev === 1'b1 && out_b === 1'b0) begin
                runs++;
                if (run_len != 102 && bad_len < 0) bad_len = run_len;
                run_len = 0;
            end
            prev = out_b;
        end
        checks++; if (first_rise !== 102) begin errors++; $display("FAIL def_first_rise: got %0d expected 102", first_rise); end
        checks++; if (bad_len !== -1) begin errors++; $display("FAIL def_high_time: got %0d expected 102", bad_len); end
        checks++; if (runs !== 10) begin errors++; $display("FAIL def_high_runs: got %0d expected 10", runs); end
        checks++; if (cnt_b !== 16'd10) begin errors++; $display("FAIL def_cnt: got %0d expected 10", cnt_b); end
        checks++; if (run_b !== 1'b1) begin errors++; $display("FAIL def_running: got %0b expected 1", run_b); end
    endtask

    task automatic test_saturate();
        logic wrapped;
        logic [3:0] prev_cnt;
        wrapped = 1'b0;
        prev_cnt = cnt_c;
        en_c = 1'b1;
        for (int e = 1; e <= 240; e++) begin
            tick();
            if (cnt_c < prev_cnt) wrapped = 1'b1;
            prev_cnt = cnt_c;
            if (e == 174) begin
                checks++; if (cnt_c !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", cnt_c); end
            end
            if (e == 173) begin
                checks++; if (cnt_c !== 4'd14) begin errors++; $display("FAIL sat_before: got %0d expected 14", cnt_c); end
            end
        end
        checks++; if (cnt_c !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", cnt_c); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL sat_wrap: got %0b expected 0", wrapped); end
    endtask

    task automatic test_async_reset();
        int waited;
        waited = 0;
        while (out_a !== 1'b1 && waited < 20) begin tick(); waited++; end
        checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL ar_pre_high: got %0b expected 1", out_a); end
        #2;
        rst_a = 1'b1;
        #1;
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL ar_out: got %0b expected 0", out_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", cnt_a); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL ar_running: got %0b expected 0", run_a); end
        checks++; if (u_a.node !== 5'b10101) begin errors++; $display("FAIL ar_nodes: got %b expected 10101", u_a.node); end
        repeat (3) tick();
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL ar_hold: got %0b expected 0", out_a); end
        rst_a = 1'b0;
        repeat (5) tick();
        checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL ar_rel_e5: got %0b expected 0", out_a); end
        tick();
        checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL ar_rel_e6: got %0b expected 1", out_a); end
        checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL ar_rel_cnt: got %0d expected 1", cnt_a); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_disable();
        test_defaults();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
